spi_tx_fifo: RTL and testbench
==============================

SPI_TX_FIFO -- requirements
Module: spi_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port write_en  input  1  push request from the producer.
REQ-006 SHALL have port write_data  input  DATA_WIDTH  word to push.
REQ-007 SHALL have port read_en  input  1  pop request from the SPI serializer.
REQ-008 SHALL have port read_data  output  DATA_WIDTH  head-of-queue word (show-ahead).
REQ-009 SHALL have port full  output  1  count == DEPTH.
REQ-010 SHALL have port empty  output  1  count == 0.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  number of stored words.
REQ-012 SHALL have ports overflow, underflow  output  1 each  sticky error flags (present only per REQ-032).

Function
REQ-013 SHALL store words in a DEPTH-entry memory addressed by write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits.
REQ-014 SHALL accept a push (write_en=1 and not full) at the clock edge: mem[wr_ptr] <= write_data, wr_ptr increments.
REQ-015 SHALL accept a pop (read_en=1 and not empty) at the clock edge: rd_ptr increments.
REQ-016 SHALL wrap both pointers from DEPTH-1 to 0 with no gap or extra cycle.
REQ-017 SHALL drive read_data combinationally as mem[rd_ptr] when not empty; all-zeros when empty.
REQ-018 SHALL present the head word in the same cycle empty is low, so the serializer captures read_data in the cycle it asserts read_en (zero-latency show-ahead).
REQ-019 SHALL ignore write_en while full: no memory write, no pointer or count change.
REQ-020 SHALL ignore read_en while empty: no pointer or count change.
REQ-021 SHALL, on simultaneous read_en and write_en when neither full nor empty, perform both; count unchanged.
REQ-022 SHALL, on simultaneous read_en and write_en when full, perform both (pop frees the slot); count stays DEPTH.
REQ-023 SHALL, on simultaneous read_en and write_en when empty, perform only the push; count becomes 1; written word visible on read_data the next cycle.
REQ-024 SHALL update count as registered: +1 push only, -1 pop only, unchanged otherwise; never exceeding DEPTH or below 0.
REQ-025 SHALL derive full and empty from registered count; full and empty SHALL never be asserted together.
REQ-026 SHALL preserve FIFO order: words read out in exact write order with no loss or duplication.

Reset
REQ-027 SHALL on rst=1 asynchronously clear wr_ptr, rd_ptr, count to 0.
REQ-028 SHALL hold outputs during and after reset at: empty=1, full=0, count=0, read_data=0, overflow=0, underflow=0.
REQ-029 SHALL not reset memory contents; stale data SHALL never appear on read_data because empty forces zeros.
REQ-030 SHALL discard all stored words on reset mid-operation; first push after release returns to normal operation.
REQ-031 SHALL ignore write_en and read_en in any cycle where rst=1.

Configuration
REQ-032 SHALL, with macro SPI_TX_FIFO_ERR_FLAGS_EN defined, provide overflow (set on write_en while full) and underflow (set on read_en while empty), both sticky until rst.
REQ-033 SHALL, without SPI_TX_FIFO_ERR_FLAGS_EN, omit overflow and underflow ports and their logic; all other behaviour identical.

Verification (DATA_WIDTH=8, DEPTH=4)
REQ-034 SHALL cover: reset, then push 0xA1,0xB2,0xC3,0xD4 -> count=4, full=1, empty=0; four pops yield 0xA1,0xB2,0xC3,0xD4 in order, then empty=1, read_data=0x00.
REQ-035 SHALL cover: full FIFO, write_en with 0xEE -> count stays 4, 0xEE never read; with ERR_FLAGS_EN overflow=1 until rst.
REQ-036 SHALL cover: empty FIFO, read_en=1 -> count=0, pointers unchanged; with ERR_FLAGS_EN underflow=1.
REQ-037 SHALL cover: empty FIFO, read_en=1 and write_en=1 with 0x5A same cycle -> next cycle count=1, read_data=0x5A.
REQ-038 SHALL cover: six push/pop cycles of 0x01..0x06 through 4 entries -> pointers wrap, data returned 0x01..0x06 in order, count never >4.
REQ-039 SHALL cover: rst asserted with count=3 -> same cycle count=0, empty=1, read_data=0x00; subsequent push 0x77 read back as 0x77.

Source files
------------

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: show-ahead transmit FIFO between a word producer and an SPI
// serializer. The head word is visible on read_data whenever empty is low,
// so the serializer can capture it in the same cycle it asserts read_en.
//
// Optional feature: define SPI_TX_FIFO_ERR_FLAGS_EN to add the sticky
// overflow / underflow error flag ports. Without it those ports and their
// logic are absent and all other behaviour is identical.
module spi_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write_en,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic                    read_en,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
`ifdef SPI_TX_FIFO_ERR_FLAGS_EN
    ,
    output logic                    overflow,
    output logic                    underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;

    // Flags come straight from the registered occupancy, so they can never
    // both be high.
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A pop is only taken when something is stored. A push is taken when
    // there is room, or when the FIFO is full but the same-cycle pop frees
    // the head slot (the new word lands in the slot being vacated).
    assign pop  = read_en && !empty;
    assign push = write_en && (!full || read_en);

    // Show-ahead head word; forced to zero when empty so stale memory
    // contents never leak out.
    assign read_data = empty ? '0 : mem[rd_ptr];

    // Storage array: no reset, writes suppressed while rst is held.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= write_data;
        end
    end

    // Pointers and occupancy; power-of-two depth gives natural wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

`ifdef SPI_TX_FIFO_ERR_FLAGS_EN
    // Sticky error flags: overflow marks a dropped write (full, no pop to
    // make room), underflow marks a read request against an empty FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_en && full && !read_en) begin
                overflow <= 1'b1;
            end
            if (read_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_tx_fifo.sv
// tb_spi_tx_fifo: bench for spi_tx_fifo (DATA_WIDTH=8, DEPTH=4). A queue
// model tracks the stored words; a negedge process compares every output
// against it each cycle, and directed scenarios add literal expectations.
module tb_spi_tx_fifo;

    localparam int DW = 8;
    localparam int DP = 4;

    logic          clk;
    logic          rst;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic          read_en;
    logic [DW-1:0] read_data;
    logic          full;
    logic          empty;
    logic [2:0]    count;
`ifdef SPI_TX_FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
    logic          m_ovf;
    logic          m_unf;
`endif

    logic [DW-1:0] q [$];
    int            n_checks;
    int            n_fail;

    spi_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .write_data (write_data),
        .read_en    (read_en),
        .read_data  (read_data),
        .full       (full),
        .empty      (empty),
        .count      (count)
`ifdef SPI_TX_FIFO_ERR_FLAGS_EN
        ,
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the queue model.
    always @(negedge clk) begin
        int n;
        logic [DW-1:0] head;
        n = q.size();
        head = (n != 0) ? q[0] : 8'h00;
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DP));
        chk("read_data", 32'(read_data), 32'(head));
`ifdef SPI_TX_FIFO_ERR_FLAGS_EN
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
`endif
    end

    // One clock with the given requests; model advances on the edge.
    task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re);
        bit m_full;
        bit m_empty;
        write_en   = we;
        write_data = wd;
        read_en    = re;
        @(posedge clk);
        if (!rst) begin
            m_full  = (q.size() == DP);
            m_empty = (q.size() == 0);
`ifdef SPI_TX_FIFO_ERR_FLAGS_EN
            if (we && m_full && !re) m_ovf = 1'b1;
            if (re && m_empty) m_unf = 1'b1;
`endif
            if (re && !m_empty) void'(q.pop_front());
            if (we && (!m_full || re)) q.push_back(wd);
        end
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
`ifdef SPI_TX_FIFO_ERR_FLAGS_EN
        m_ovf = 1'b0;
        m_unf = 1'b0;
`endif
    endtask

    task automatic pop_expect(input string name, input logic [DW-1:0] exp);
        chk(name, 32'(read_data), 32'(exp));
        cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        write_en   = 1'b0;
        write_data = '0;
        read_en    = 1'b0;
        model_reset();
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h99, 1'b1);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_rdata", 32'(read_data), 32'd0);
        rst = 1'b0;

        // Fill with four words then drain in order.
        cycle(1'b1, 8'hA1, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0);
        cycle(1'b1, 8'hD4, 1'b0);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_empty", 32'(empty), 32'd0);
        pop_expect("pop0", 8'hA1);
        pop_expect("pop1", 8'hB2);
        pop_expect("pop2", 8'hC3);
        pop_expect("pop3", 8'hD4);
        chk("drained_empty", 32'(empty), 32'd1);
        chk("drained_rdata", 32'(read_data), 32'd0);

        // Write while full is dropped.
        for (int i = 0; i < DP; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0);
        cycle(1'b1, 8'hEE, 1'b0);
        chk("ovf_count", 32'(count), 32'd4);
`ifdef SPI_TX_FIFO_ERR_FLAGS_EN
        chk("ovf_flag", 32'(overflow), 32'd1);
`endif
        pop_expect("ovf_pop0", 8'h11);
        pop_expect("ovf_pop1", 8'h12);
        pop_expect("ovf_pop2", 8'h13);
        pop_expect("ovf_pop3", 8'h14);

        // Read while empty is ignored.
        cycle(1'b0, 8'h00, 1'b1);
        chk("unf_count", 32'(count), 32'd0);
`ifdef SPI_TX_FIFO_ERR_FLAGS_EN
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("ovf_sticky", 32'(overflow), 32'd1);
`endif

        // Simultaneous read/write on empty: push only.
        cycle(1'b1, 8'h5A, 1'b1);
        chk("rw_empty_count", 32'(count), 32'd1);
        chk("rw_empty_rdata", 32'(read_data), 32'h5A);
        pop_expect("rw_empty_pop", 8'h5A);

        // Streaming through the pointer wrap.
        cycle(1'b1, 8'h01, 1'b0);
        for (int i = 2; i <= 6; i++) begin
            chk("wrap_head", 32'(read_data), 32'(i - 1));
            cycle(1'b1, 8'(i), 1'b1);
            chk("wrap_count", 32'(count), 32'd1);
        end
        pop_expect("wrap_last", 8'h06);

        // Simultaneous read/write on full: both happen.
        for (int i = 0; i < DP; i++) cycle(1'b1, 8'(8'h21 + i), 1'b0);
        cycle(1'b1, 8'h25, 1'b1);
        chk("rw_full_count", 32'(count), 32'd4);
        pop_expect("rw_full_pop0", 8'h22);
        pop_expect("rw_full_pop1", 8'h23);
        pop_expect("rw_full_pop2", 8'h24);
        pop_expect("rw_full_pop3", 8'h25);

        // Randomized traffic: write-heavy then read-heavy phases.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = ((i / 150) % 2 == 0) ? 70 : 30;
            cycle($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) >= wp);
        end

        // Reset mid-operation with three words stored.
        do_reset();
        cycle(1'b1, 8'h31, 1'b0);
        cycle(1'b1, 8'h32, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd3);
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_rdata", 32'(read_data), 32'd0);
        cycle(1'b1, 8'h44, 1'b1);
        rst = 1'b0;
        cycle(1'b1, 8'h77, 1'b0);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_rdata", 32'(read_data), 32'h77);
        pop_expect("post_rst_pop", 8'h77);
        cycle(1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
